mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 27 ++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester A/B, memory-side and status signals of the two-port memory arbiter.
// The arbiter takes the slave view; the requesters/memory side take the master view.
interface mem_arbiter_if;
  logic        a_req, a_we, a_word, a_ack, a_err;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_word, b_ack, b_err;
  logic [15:0] b_addr, b_wdata, b_rdata;
  logic        mem_wr_enable, mem_rd_enable, mem_word;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  modport slave (
    input  a_req, a_we, a_word, a_addr, a_wdata,
    input  b_req, b_we, b_word, b_addr, b_wdata,
    input  mem_rdata,
    output a_ack, a_err, a_rdata, b_ack, b_err, b_rdata,
    output mem_wr_enable, mem_rd_enable, mem_word, mem_addr, mem_wdata, busy
  );

  modport master (
    output a_req, a_we, a_word, a_addr, a_wdata,
    output b_req, b_we, b_word, b_addr, b_wdata,
    output mem_rdata,
    input  a_ack, a_err, a_rdata, b_ack, b_err, b_rdata,
    input  mem_wr_enable, mem_rd_enable, mem_word, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fixed priority A over B with a starvation guard for B,
// one transaction per IDLE -> ISSUE -> DONE pass.
module mem_arbiter #(
  parameter int MEM_BYTES    = 1024,
  parameter int STARVE_LIMIT = 3
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [16:0] LIM  = 17'(MEM_BYTES);
  localparam logic [2:0]  SLIM = 3'(STARVE_LIMIT);

  state_t      r_state, w_next;
  logic [2:0]  r_starve;
  logic        r_cmd_b, r_cmd_we, r_cmd_word, r_cmd_err;
  logic [15:0] r_cmd_addr, r_cmd_wdata;
  logic        r_wr_en, r_rd_en, r_a_ack, r_a_err, r_b_ack, r_b_err;
  logic [15:0] r_a_rdata, r_b_rdata;

  logic        w_any, w_pick_b, w_we, w_word, w_err;
  logic [15:0] w_addr, w_wdata;
  logic        w_wr_nxt, w_rd_nxt, w_a_ack_nxt, w_a_err_nxt, w_b_ack_nxt, w_b_err_nxt;
  logic [15:0] w_a_rdata, w_b_rdata;

  assign w_any    = bus.a_req | bus.b_req;
  assign w_pick_b = bus.b_req & (~bus.a_req | (r_starve == SLIM));
  assign w_we     = w_pick_b ? bus.b_we    : bus.a_we;
  assign w_word   = w_pick_b ? bus.b_word  : bus.a_word;
  assign w_addr   = w_pick_b ? bus.b_addr  : bus.a_addr;
  assign w_wdata  = w_pick_b ? bus.b_wdata : bus.a_wdata;
  // A 16-bit access at the last byte would run off the end of memory.
  assign w_err    = ({1'b0, w_addr} >= LIM) | (w_word & ({1'b0, w_addr} == LIM - 17'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_cmd_b     <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_word  <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_a_ack     <= 1'b0;
      r_a_err     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_b_err     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      r_state   <= w_next;
      r_wr_en   <= w_wr_nxt;
      r_rd_en   <= w_rd_nxt;
      r_a_ack   <= w_a_ack_nxt;
      r_a_err   <= w_a_err_nxt;
      r_b_ack   <= w_b_ack_nxt;
      r_b_err   <= w_b_err_nxt;
      r_a_rdata <= w_a_rdata;
      r_b_rdata <= w_b_rdata;
      if (r_state == IDLE && w_any) begin
        r_cmd_b     <= w_pick_b;
        r_cmd_we    <= w_we;
        r_cmd_word  <= w_word;
        r_cmd_err   <= w_err;
        r_cmd_addr  <= w_addr;
        r_cmd_wdata <= w_wdata;
        if (w_pick_b || !bus.b_req) r_starve <= '0;
        else if (r_starve != SLIM)  r_starve <= r_starve + 3'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; read data is passed through live in DONE
  // because the memory only presents it in that cycle, then held by r_*_rdata.
  always_comb begin
    w_wr_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_a_ack_nxt = 1'b0;
    w_a_err_nxt = 1'b0;
    w_b_ack_nxt = 1'b0;
    w_b_err_nxt = 1'b0;
    w_a_rdata   = r_a_rdata;
    w_b_rdata   = r_b_rdata;
    case (r_state)
      IDLE: if (w_any) begin
        w_wr_nxt = w_we & ~w_err;
        w_rd_nxt = ~w_we & ~w_err;
      end
      ISSUE: begin
        w_a_ack_nxt = ~r_cmd_b;
        w_a_err_nxt = ~r_cmd_b & r_cmd_err;
        w_b_ack_nxt = r_cmd_b;
        w_b_err_nxt = r_cmd_b & r_cmd_err;
      end
      DONE: if (!r_cmd_we) begin
        if (r_cmd_b) w_b_rdata = r_cmd_err ? 16'h0000 : bus.mem_rdata;
        else         w_a_rdata = r_cmd_err ? 16'h0000 : bus.mem_rdata;
      end
      default: ;
    endcase
  end

  assign bus.mem_wr_enable = r_wr_en;
  assign bus.mem_rd_enable = r_rd_en;
  assign bus.mem_addr      = r_cmd_addr;
  assign bus.mem_wdata     = r_cmd_wdata;
  assign bus.mem_word      = r_cmd_word;
  assign bus.a_ack         = r_a_ack;
  assign bus.a_err         = r_a_err;
  assign bus.a_rdata       = w_a_rdata;
  assign bus.b_ack         = r_b_ack;
  assign bus.b_err         = r_b_err;
  assign bus.b_rdata       = w_b_rdata;
  assign bus.busy          = (r_state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1 KiB byte memory model (registered read bus).
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_arbiter_if bus ();
  mem_arbiter #(.MEM_BYTES(1024), .STARVE_LIMIT(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.mem_wr_enable) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata[7:0];
      if (bus.mem_word) mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_wdata[15:8];
    end
    if (bus.mem_rd_enable)
      bus.mem_rdata <= bus.mem_word ? {mem[bus.mem_addr[9:0] + 10'd1], mem[bus.mem_addr[9:0]]}
                                    : {8'h00, mem[bus.mem_addr[9:0]]};
  end

  task automatic set_a(input logic req, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic word);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata; bus.a_word = word;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic word);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata; bus.b_word = word;
  endtask

  task automatic test_reset;
    logic [7:0]  ctl;
    logic [63:0] dat;
    reset_n = 1'b0;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    ctl = {bus.busy, bus.mem_wr_enable, bus.mem_rd_enable, bus.mem_word,
           bus.a_ack, bus.a_err, bus.b_ack, bus.b_err};
    dat = {bus.a_rdata, bus.b_rdata, bus.mem_addr, bus.mem_wdata};
    n_checks++; if (ctl !== 8'h00) begin n_fail++; $display("FAIL reset_ctl got %h want 00", ctl); end
    n_checks++; if (dat !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", dat); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req busy got %b want 0", bus.busy); end
  endtask

  task automatic test_a_read;
    set_a(1, 0, 16'd2, 16'h0, 1);
    @(negedge clk);
    n_checks++;
    if ({bus.mem_rd_enable, bus.mem_wr_enable, bus.busy, bus.a_ack, bus.mem_addr} !== {4'b1010, 16'd2}) begin
      n_fail++; $display("FAIL a_read_issue got rd=%b wr=%b busy=%b ack=%b addr=%h want 1 0 1 0 0002",
                         bus.mem_rd_enable, bus.mem_wr_enable, bus.busy, bus.a_ack, bus.mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.a_ack, bus.a_err, bus.b_ack, bus.mem_rd_enable, bus.a_rdata} !== {4'b1000, 16'h0302}) begin
      n_fail++; $display("FAIL a_read_done got ack=%b err=%b back=%b rd=%b rdata=%h want 1 0 0 0 0302",
                         bus.a_ack, bus.a_err, bus.b_ack, bus.mem_rd_enable, bus.a_rdata);
    end
    bus.a_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.a_ack, bus.busy, bus.a_rdata} !== {2'b00, 16'h0302}) begin
      n_fail++; $display("FAIL a_read_after got ack=%b busy=%b rdata=%h want 0 0 0302",
                         bus.a_ack, bus.busy, bus.a_rdata);
    end
  endtask

  task automatic test_b_write_read;
    set_b(1, 1, 16'd10, 16'hABCD, 0);
    @(negedge clk);
    n_checks++;
    if ({bus.mem_wr_enable, bus.mem_rd_enable, bus.mem_word, bus.mem_wdata} !== {3'b100, 16'hABCD}) begin
      n_fail++; $display("FAIL b_write_issue got wr=%b rd=%b word=%b wdata=%h want 1 0 0 abcd",
                         bus.mem_wr_enable, bus.mem_rd_enable, bus.mem_word, bus.mem_wdata);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.b_ack, bus.b_err, bus.a_ack, bus.b_rdata} !== {3'b100, 16'h0000}) begin
      n_fail++; $display("FAIL b_write_done got ack=%b err=%b aack=%b rdata=%h want 1 0 0 0000",
                         bus.b_ack, bus.b_err, bus.a_ack, bus.b_rdata);
    end
    bus.b_req = 1'b0;
    @(negedge clk);
    set_b(1, 0, 16'd10, 16'h0, 0);
    @(negedge clk);
    n_checks++;
    if ({bus.mem_rd_enable, bus.mem_wr_enable} !== 2'b10) begin
      n_fail++; $display("FAIL b_read_issue got rd=%b wr=%b want 1 0", bus.mem_rd_enable, bus.mem_wr_enable);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.b_ack, bus.b_rdata, bus.a_rdata} !== {1'b1, 16'h00CD, 16'h0302}) begin
      n_fail++; $display("FAIL b_read_done got ack=%b b_rdata=%h a_rdata=%h want 1 00cd 0302",
                         bus.b_ack, bus.b_rdata, bus.a_rdata);
    end
    bus.b_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_range;
    logic [15:0] addrs [3];
    logic        words [3];
    logic        errs  [3];
    logic [15:0] exps  [3];
    addrs = '{16'd1023, 16'd1023, 16'h0400};
    words = '{1'b0, 1'b1, 1'b0};
    errs  = '{1'b0, 1'b1, 1'b1};
    exps  = '{16'h00FF, 16'h0000, 16'h0000};
    for (int k = 0; k < 3; k++) begin
      set_a(1, 0, addrs[k], 16'h0, words[k]);
      @(negedge clk);
      n_checks++;
      if ({bus.mem_wr_enable, bus.mem_rd_enable} !== {1'b0, ~errs[k]}) begin
        n_fail++; $display("FAIL range_issue_%0d got wr=%b rd=%b want 0 %b",
                           k, bus.mem_wr_enable, bus.mem_rd_enable, ~errs[k]);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.a_ack, bus.a_err, bus.a_rdata} !== {1'b1, errs[k], exps[k]}) begin
        n_fail++; $display("FAIL range_done_%0d got ack=%b err=%b rdata=%h want 1 %b %h",
                           k, bus.a_ack, bus.a_err, bus.a_rdata, errs[k], exps[k]);
      end
      bus.a_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_field_change;
    set_a(1, 0, 16'd2, 16'h0, 1);
    @(negedge clk);
    bus.a_addr = 16'd4;
    bus.a_word = 1'b0;
    n_checks++;
    if ({bus.mem_rd_enable, bus.mem_addr} !== {1'b1, 16'd2}) begin
      n_fail++; $display("FAIL field_issue got rd=%b addr=%h want 1 0002", bus.mem_rd_enable, bus.mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.a_ack, bus.a_rdata, bus.mem_addr} !== {1'b1, 16'h0302, 16'd2}) begin
      n_fail++; $display("FAIL field_done got ack=%b rdata=%h addr=%h want 1 0302 0002",
                         bus.a_ack, bus.a_rdata, bus.mem_addr);
    end
    bus.a_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] order = '0;
    int n = 0, overlap = 0, idle_run = 0, gaps = 0, bad_data = 0;
    set_a(1, 0, 16'd4, 16'h0, 0);
    set_b(1, 0, 16'd6, 16'h0, 0);
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      @(negedge clk);
      if (bus.a_ack && bus.b_ack) overlap++;
      if (!bus.busy) idle_run++; else idle_run = 0;
      if (idle_run > 1) gaps++;
      if (bus.a_ack) begin
        if (bus.a_rdata !== 16'h0004) bad_data++;
        if (n < 8) order[n] = 1'b0;
        n++;
      end
      if (bus.b_ack) begin
        if (bus.b_rdata !== 16'h0006) bad_data++;
        if (n < 8) order[n] = 1'b1;
        n++;
      end
      if (n >= 8) begin bus.a_req = 1'b0; bus.b_req = 1'b0; end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL b2b_count got %0d acks want 8", n); end
    n_checks++; if (order !== 8'h88) begin n_fail++; $display("FAIL b2b_order got %b want 10001000 (bit0 first, 1=B)", order); end
    n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL b2b_overlap got %0d want 0", overlap); end
    n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL b2b_busy_gap got %0d want 0", gaps); end
    n_checks++; if (bad_data !== 0) begin n_fail++; $display("FAIL b2b_rdata got %0d bad want 0", bad_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    logic [7:0] ctl;
    set_a(1, 1, 16'd20, 16'h1234, 1);
    @(negedge clk);
    n_checks++;
    if (bus.mem_wr_enable !== 1'b1) begin n_fail++; $display("FAIL rst_mid_issue got wr=%b want 1", bus.mem_wr_enable); end
    #2 reset_n = 1'b0;
    #1;
    ctl = {bus.busy, bus.mem_wr_enable, bus.mem_rd_enable, bus.mem_word,
           bus.a_ack, bus.a_err, bus.b_ack, bus.b_err};
    n_checks++;
    if ({ctl, bus.mem_addr, bus.mem_wdata, bus.a_rdata} !== 56'h0) begin
      n_fail++; $display("FAIL rst_mid_outputs got ctl=%h addr=%h wdata=%h rdata=%h want all 0",
                         ctl, bus.mem_addr, bus.mem_wdata, bus.a_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.a_ack, bus.busy, mem[21], mem[20]} !== {2'b00, 16'h1514}) begin
      n_fail++; $display("FAIL rst_mid_abort got ack=%b busy=%b mem=%h want 0 0 1514",
                         bus.a_ack, bus.busy, {mem[21], mem[20]});
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.mem_wr_enable, bus.a_ack} !== 3'b110) begin
      n_fail++; $display("FAIL rst_retry_issue got busy=%b wr=%b ack=%b want 1 1 0",
                         bus.busy, bus.mem_wr_enable, bus.a_ack);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.a_ack, bus.a_err} !== 2'b10) begin
      n_fail++; $display("FAIL rst_retry_ack got ack=%b err=%b want 1 0", bus.a_ack, bus.a_err);
    end
    bus.a_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem[21], mem[20]} !== 16'h1234) begin
      n_fail++; $display("FAIL rst_retry_mem got %h want 1234", {mem[21], mem[20]});
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    bus.mem_rdata = 16'h0;
    test_reset;
    test_a_read;
    test_b_write_read;
    test_range;
    test_field_change;
    test_back_to_back;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after 100000 time units");
    $fatal(1, "watchdog");
  end
endmodule
